// File: rtl/tipi_link_master.sv
// tipi_link_master: Pi-side initiator for the TIPI register link.
// Serialises single RC/RD writes and TC/TD reads onto r_clk/r_le/r_dout/r_din.
module tipi_link_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_reg,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_parity_err,
  output logic       busy,
  output logic       r_clk,
  output logic       r_rt,
  output logic       r_cd,
  output logic       r_le,
  output logic       r_dout,
  input  logic       r_din
);

  // state    | meaning
  // IDLE     | waiting for a request, req_ready high
  // WR_SHIFT | write periods 1-8, data bits out MSB first
  // WR_LATCH | write period 9, r_le strobe
  // WR_PAR   | write period 10, returned parity sampled
  // RD_LOAD  | read period 1, r_le makes the CPLD load its register
  // RD_SHIFT | read periods 2-9, data bits in MSB first
  // DONE     | one-cycle completion, rsp_valid high
  typedef enum logic [2:0] {
    IDLE, WR_SHIFT, WR_LATCH, WR_PAR, RD_LOAD, RD_SHIFT, DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] WR_LAST  = 4'd9;
  localparam logic [3:0] RD_LAST  = 4'd8;

  state_t     state_q, state_n;
  logic [7:0] div_q, div_n;
  logic [3:0] per_q, per_n;
  logic [7:0] data_q, data_n;
  logic [6:0] shreg_q, shreg_n;
  logic       clk_n, rt_n, cd_n, le_n, dout_n;
  logic       vld_n, perr_n;
  logic [7:0] rdata_n;
  logic       div_wrap, per_end;

  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;

  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    per_n   = per_q;
    data_n  = data_q;
    shreg_n = shreg_q;
    clk_n   = r_clk;
    rt_n    = r_rt;
    cd_n    = r_cd;
    le_n    = r_le;
    dout_n  = r_dout;
    vld_n   = 1'b0;
    rdata_n = rsp_data;
    perr_n  = rsp_parity_err;

    div_wrap = (div_q == DIV_LAST);
    per_end  = r_clk && div_wrap;

    if (state_q != IDLE && state_q != DONE) begin
      div_n = div_wrap ? 8'd0 : div_q + 8'd1;
      if (div_wrap) clk_n = ~r_clk;
    end

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          data_n  = req_data;
          rt_n    = req_reg[1];
          cd_n    = req_reg[0];
          per_n   = 4'd0;
          div_n   = 8'd0;
          clk_n   = 1'b0;
          shreg_n = 7'd0;
          if (req_reg[1]) begin
            state_n = RD_LOAD;
            le_n    = 1'b1;
            dout_n  = 1'b0;
          end else begin
            state_n = WR_SHIFT;
            le_n    = 1'b0;
            dout_n  = req_data[7];
          end
        end
      end
      WR_SHIFT: begin
        if (per_end) begin
          per_n = per_q + 4'd1;
          if (per_q == 4'd7) begin
            state_n = WR_LATCH;
            le_n    = 1'b1;
            dout_n  = 1'b0;
          end else begin
            // bit for the next period: index 7 - (per_q + 1)
            dout_n = data_q[3'd6 - per_q[2:0]];
          end
        end
      end
      WR_LATCH: begin
        if (per_end) begin
          per_n   = per_q + 4'd1;
          state_n = WR_PAR;
          le_n    = 1'b0;
        end
      end
      WR_PAR: begin
        if (per_end && per_q == WR_LAST) begin
          state_n = DONE;
          vld_n   = 1'b1;
          rdata_n = data_q;
          perr_n  = r_din ^ (^data_q);
          per_n   = 4'd0;
          div_n   = 8'd0;
          clk_n   = 1'b0;
          rt_n    = 1'b0;
          cd_n    = 1'b0;
          le_n    = 1'b0;
          dout_n  = 1'b0;
        end
      end
      RD_LOAD: begin
        if (per_end) begin
          per_n   = per_q + 4'd1;
          state_n = RD_SHIFT;
          le_n    = 1'b0;
        end
      end
      RD_SHIFT: begin
        if (per_end) begin
          per_n   = per_q + 4'd1;
          shreg_n = {shreg_q[5:0], r_din};
          if (per_q == RD_LAST) begin
            state_n = DONE;
            vld_n   = 1'b1;
            rdata_n = {shreg_q, r_din};
            perr_n  = 1'b0;
            per_n   = 4'd0;
            div_n   = 8'd0;
            clk_n   = 1'b0;
            rt_n    = 1'b0;
            cd_n    = 1'b0;
            le_n    = 1'b0;
            dout_n  = 1'b0;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      div_q          <= 8'd0;
      per_q          <= 4'd0;
      data_q         <= 8'd0;
      shreg_q        <= 7'd0;
      r_clk          <= 1'b0;
      r_rt           <= 1'b0;
      r_cd           <= 1'b0;
      r_le           <= 1'b0;
      r_dout         <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= 8'd0;
      rsp_parity_err <= 1'b0;
    end else begin
      state_q        <= state_n;
      div_q          <= div_n;
      per_q          <= per_n;
      data_q         <= data_n;
      shreg_q        <= shreg_n;
      r_clk          <= clk_n;
      r_rt           <= rt_n;
      r_cd           <= cd_n;
      r_le           <= le_n;
      r_dout         <= dout_n;
      rsp_valid      <= vld_n;
      rsp_data       <= rdata_n;
      rsp_parity_err <= perr_n;
    end
  end

endmodule

// File: tb/tb_tipi_link_master.sv
// Bench for tipi_link_master: three instances (CLK_DIV 1, 2, 4) driven against a
// behavioural CPLD model and a transaction-level expectation model.
module tb_tipi_link_master;

  localparam int NDUT = 3;
  localparam int DIVS [NDUT] = '{1, 2, 4};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic       req_valid [NDUT];
  logic       req_ready [NDUT];
  logic [1:0] req_reg   [NDUT];
  logic [7:0] req_data  [NDUT];
  logic       rsp_valid [NDUT];
  logic [7:0] rsp_data  [NDUT];
  logic       rsp_perr  [NDUT];
  logic       busy      [NDUT];
  logic       r_clk     [NDUT];
  logic       r_rt      [NDUT];
  logic       r_cd      [NDUT];
  logic       r_le      [NDUT];
  logic       r_dout    [NDUT];
  logic       r_din     [NDUT] = '{default: 1'b0};

  // CPLD model state (written only by the model process)
  bit          prev_clk [NDUT] = '{default: 1'b0};
  int          edge_cnt [NDUT] = '{default: 0};
  int          sel_bad  [NDUT] = '{default: 0};
  logic [15:0] log_dout [NDUT] = '{default: 16'd0};
  logic [15:0] log_le   [NDUT] = '{default: 16'd0};
  logic [7:0]  sr       [NDUT] = '{default: 8'd0};
  bit          pend     [NDUT] = '{default: 1'b0};

  // model configuration (written only by the stimulus process)
  logic [7:0] tx_byte [NDUT];
  logic       par_ret [NDUT];
  logic [1:0] exp_sel [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    tipi_link_master #(.CLK_DIV(DIVS[g])) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid[g]),
      .req_ready      (req_ready[g]),
      .req_reg        (req_reg[g]),
      .req_data       (req_data[g]),
      .rsp_valid      (rsp_valid[g]),
      .rsp_data       (rsp_data[g]),
      .rsp_parity_err (rsp_perr[g]),
      .busy           (busy[g]),
      .r_clk          (r_clk[g]),
      .r_rt           (r_rt[g]),
      .r_cd           (r_cd[g]),
      .r_le           (r_le[g]),
      .r_dout         (r_dout[g]),
      .r_din          (r_din[g])
    );
  end

  // CPLD: logs link pins at each r_clk rise, loads on r_le, shifts r_din out on falls
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (r_clk[i] === 1'b1 && prev_clk[i] == 1'b0) begin
        edge_cnt[i] <= edge_cnt[i] + 1;
        log_dout[i] <= {log_dout[i][14:0], r_dout[i]};
        log_le[i]   <= {log_le[i][14:0], r_le[i]};
        if ({r_rt[i], r_cd[i]} !== exp_sel[i]) sel_bad[i] <= sel_bad[i] + 1;
        if (r_le[i] === 1'b1) begin
          if (r_rt[i] === 1'b1) sr[i] <= tx_byte[i];
          else pend[i] <= 1'b1;
        end
      end else if (r_clk[i] === 1'b0 && prev_clk[i] == 1'b1) begin
        if (pend[i]) begin
          r_din[i] <= par_ret[i];
          pend[i]  <= 1'b0;
        end else begin
          r_din[i] <= sr[i][7];
          sr[i]    <= {sr[i][6:0], 1'b0};
        end
      end
      prev_clk[i] <= (r_clk[i] === 1'b1);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One transaction on instance i; called and returns on a falling clk edge.
  task automatic run_xfer(input int i, input logic [1:0] rg, input logic [7:0] d,
                          input logic par, input bit hold,
                          output int t_acc, output int t_rsp);
    int n, lat_exp, e0, bad0, wait_n, busy_bad;
    logic [15:0] mask, exp_dout, exp_le;
    logic exp_err;
    string tg;
    tg       = $sformatf("u%0d_reg%0d_%02h", i, rg, d);
    n        = rg[1] ? 9 : 10;
    lat_exp  = 1 + 2 * n * DIVS[i];
    exp_err  = rg[1] ? 1'b0 : (par ^ (^d));
    mask     = 16'((1 << n) - 1);
    exp_dout = {6'd0, d, 2'b00};
    exp_le   = rg[1] ? 16'h0100 : 16'h0002;
    tx_byte[i] = d;
    par_ret[i] = par;
    exp_sel[i] = rg;
    e0   = edge_cnt[i];
    bad0 = sel_bad[i];
    req_reg[i]   = rg;
    req_data[i]  = rg[1] ? 8'($urandom) : d;
    req_valid[i] = 1'b1;
    wait_n = 0;
    while (req_ready[i] !== 1'b1 && wait_n < 8) begin
      @(negedge clk);
      wait_n++;
    end
    check_eq({tg, "_accept"}, 32'(req_ready[i]), 32'd1);
    t_acc = cyc;
    @(negedge clk);
    if (!hold) req_valid[i] = 1'b0;
    busy_bad = 0;
    wait_n = 0;
    while (rsp_valid[i] !== 1'b1 && wait_n < lat_exp + 16) begin
      if (req_ready[i] !== 1'b0 || busy[i] !== 1'b1) busy_bad++;
      @(negedge clk);
      wait_n++;
    end
    if (req_ready[i] !== 1'b0 || busy[i] !== 1'b1) busy_bad++;
    t_rsp = cyc;
    check_eq({tg, "_rsp_seen"}, 32'(rsp_valid[i]), 32'd1);
    check_eq({tg, "_latency"}, 32'(t_rsp - t_acc), 32'(lat_exp));
    check_eq({tg, "_data"}, 32'(rsp_data[i]), 32'(d));
    check_eq({tg, "_perr"}, 32'(rsp_perr[i]), 32'(exp_err));
    check_eq({tg, "_edges"}, 32'(edge_cnt[i] - e0), 32'(n));
    check_eq({tg, "_le_seq"}, 32'(log_le[i] & mask), 32'(exp_le));
    if (!rg[1]) check_eq({tg, "_dout_seq"}, 32'(log_dout[i] & mask), 32'(exp_dout & mask));
    check_eq({tg, "_sel_stable"}, 32'(sel_bad[i] - bad0), 32'd0);
    check_eq({tg, "_busy"}, 32'(busy_bad), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int ta, tr, ta2, tr2, e0, budget, inst;
    logic [1:0] rg;
    logic [7:0] d, exp_hold;
    logic par, seen;

    for (int i = 0; i < NDUT; i++) begin
      req_valid[i] = 1'b0;
      req_reg[i]   = 2'b00;
      req_data[i]  = 8'h00;
      tx_byte[i]   = 8'h00;
      par_ret[i]   = 1'b0;
      exp_sel[i]   = 2'b00;
    end

    // reset held while requests toggle
    rst_n = 1'b0;
    repeat (8) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) req_valid[i] = ~req_valid[i];
    end
    for (int i = 0; i < NDUT; i++) begin
      check_eq($sformatf("u%0d_rst_outs", i),
               32'({r_clk[i], r_rt[i], r_cd[i], r_le[i], r_dout[i], busy[i],
                    rsp_valid[i], rsp_perr[i], req_ready[i]}), 32'h001);
      check_eq($sformatf("u%0d_rst_data", i), 32'(rsp_data[i]), 32'd0);
      check_eq($sformatf("u%0d_rst_edges", i), 32'(edge_cnt[i]), 32'd0);
      req_valid[i] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed cases
    run_xfer(1, 2'b01, 8'hA5, 1'b0, 1'b0, ta, tr);
    @(negedge clk);
    run_xfer(1, 2'b00, 8'h01, 1'b0, 1'b0, ta, tr);
    @(negedge clk);
    run_xfer(2, 2'b11, 8'h3C, 1'b0, 1'b0, ta, tr);
    @(negedge clk);
    run_xfer(0, 2'b01, 8'hC3, 1'b1, 1'b0, ta, tr);
    @(negedge clk);
    run_xfer(0, 2'b10, 8'h96, 1'b0, 1'b0, ta, tr);
    @(negedge clk);

    // back-to-back with req_valid held high
    e0 = edge_cnt[2];
    run_xfer(2, 2'b10, 8'($urandom), 1'b0, 1'b1, ta, tr);
    run_xfer(2, 2'b00, 8'($urandom), 1'($urandom), 1'b0, ta2, tr2);
    check_eq("b2b_accept_cycle", 32'(ta2), 32'(tr + 1));
    check_eq("b2b_total_edges", 32'(edge_cnt[2] - e0), 32'd19);
    @(negedge clk);

    // reset during WR_SHIFT period 4 while r_clk is high
    e0 = edge_cnt[2];
    exp_sel[2]   = 2'b00;
    req_reg[2]   = 2'b00;
    req_data[2]  = 8'h5A;
    req_valid[2] = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b0;
    budget = 0;
    while (!((edge_cnt[2] - e0) == 4 && r_clk[2] === 1'b1) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check_eq("midrst_reached_p4", 32'({r_clk[2], busy[2]}), 32'h3);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_rclk_low", 32'(r_clk[2]), 32'd0);
    check_eq("midrst_ready", 32'({req_ready[2], busy[2]}), 32'h2);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= rsp_valid[2];
    end
    rst_n = 1'b1;
    e0 = edge_cnt[2];
    repeat (100) begin
      @(negedge clk);
      seen |= rsp_valid[2];
    end
    check_eq("midrst_no_rsp", 32'(seen), 32'd0);
    check_eq("midrst_no_edges", 32'(edge_cnt[2] - e0), 32'd0);
    run_xfer(2, 2'b10, 8'($urandom), 1'b0, 1'b0, ta, tr);
    @(negedge clk);

    // randomized transactions across all dividers
    repeat (15) begin
      inst = $urandom_range(0, NDUT - 1);
      rg   = 2'($urandom);
      d    = 8'($urandom);
      par  = 1'($urandom);
      run_xfer(inst, rg, d, par, 1'b0, ta, tr);
      exp_hold = d;
      repeat (3) @(negedge clk);
      check_eq($sformatf("u%0d_rsp_hold", inst), 32'(rsp_data[inst]), 32'(exp_hold));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tipi_link_master.md
# tipi_link_master

Raspberry Pi–side initiator for the TIPI register link. It converts single register transactions into the serial link waveform consumed by the TIPI CPLD: generated `r_clk`, `r_rt`/`r_cd` register select, `r_le` latch strobe and `r_dout`/`r_din` data. It writes the Pi-output registers RC/RD and checks the returned parity, and it reads the TI-output registers TC/TD. It sits between a host-side bus agent (or a test harness standing in for the Pi) and the link pins.

## Interface
- `CLK_DIV`, default 4: clk cycles per `r_clk` half-period; legal range 1..255.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: transaction request.
- `req_ready` out 1: high only in IDLE; a transfer is accepted on the edge where `req_valid && req_ready`.
- `req_reg` in 2: `{rt,cd}` select. 00 = RC write, 01 = RD write, 10 = TC read, 11 = TD read.
- `req_data` in 8: byte to write; ignored for reads.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 8: byte read, or an echo of the byte written; held until the next completion.
- `rsp_parity_err` out 1: write parity mismatch; always 0 for reads; held with `rsp_data`.
- `busy` out 1: transfer in progress; equals `~req_ready`.
- `r_clk` out 1: link clock; idles low.
- `r_rt` out 1, `r_cd` out 1: register select; held constant for the whole transfer.
- `r_le` out 1: latch/load strobe.
- `r_dout` out 1: serial data to the CPLD.
- `r_din` in 1: serial data or parity from the CPLD; already synchronous to `r_clk`.

## Operation
- Reset values:
  - `r_clk`, `r_rt`, `r_cd`, `r_le`, `r_dout` = 0.
  - `req_ready` = 1.
  - `busy`, `rsp_valid`, `rsp_parity_err` = 0; `rsp_data` = 0x00.
- States: IDLE, WR_SHIFT, WR_LATCH, WR_PAR, RD_LOAD, RD_SHIFT, DONE.
- Link period: `r_clk` is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - `r_rt`, `r_cd`, `r_le`, `r_dout` change only on the first cycle of a low phase.
  - `r_din` is sampled on the last clk cycle of a high phase.
- Accept: latch `req_reg` and `req_data`. If `req_reg[1]`=0 go to WR_SHIFT, else go to RD_LOAD.
- Write transfer, 10 periods:
  - WR_SHIFT, periods 1–8: `r_le`=0; `r_dout` = `req_data[7]`, then `[6]` … `[0]` (MSB first).
  - WR_LATCH, period 9: `r_le`=1, `r_dout`=0.
  - WR_PAR, period 10: `r_le`=0; sample `r_din` as returned parity.
  - Then `rsp_parity_err` = `r_din_sample XOR (^req_data)` (even parity); `rsp_data` = `req_data`.
- Read transfer, 9 periods:
  - RD_LOAD, period 1: `r_le`=1.
  - RD_SHIFT, periods 2–9: `r_le`=0; the sampled `r_din` shifts in MSB first, so the first sample is `rsp_data[7]`.
- DONE lasts one cycle:
  - `rsp_valid`=1 and `busy` stays 1.
  - `r_rt`, `r_cd`, `r_le`, `r_dout` return to 0 and `r_clk` is low.
  - Next cycle: IDLE, `req_ready`=1.
- Counters:
  - Divider counter counts 0..CLK_DIV-1 and wraps.
  - Period counter counts 0..9; the terminal value is 9 for writes and 8 for reads.
- Boundary conditions:
  - A request during a transfer or on the DONE cycle is not accepted and has no effect; the requester keeps `req_valid` asserted.
  - Back-to-back requests are accepted on the first IDLE cycle after DONE.
  - `rst_n` asserted mid-transfer forces reset values immediately. No `rsp_valid` is produced, and `r_clk` drops low even inside a high phase.
  - With CLK_DIV=1, `r_clk` toggles every cycle and sampling falls on the single high-phase cycle.

## Timing
- Accept edge T → first low phase starts at cycle T+1.
- Rising edges of `r_clk` occur at T+1+CLK_DIV+2k·CLK_DIV, for k = 0..N-1.
- `rsp_valid` is high in cycle T+1+2N·CLK_DIV, with N=10 for writes and N=9 for reads.
- `req_ready` is high again in cycle T+2+2N·CLK_DIV.
- Write latency at CLK_DIV=4: 81 cycles to `rsp_valid`. Read latency: 73 cycles.
- `rsp_data` and `rsp_parity_err` are valid in the `rsp_valid` cycle and stable until the next DONE.

## Test plan
- Reset: hold `rst_n`=0 and toggle `req_valid`. Required: all outputs at their reset values, `req_ready`=1, no `r_clk` edges.
- Write RD 0xA5 at CLK_DIV=2, with the CPLD model returning parity 0. Required:
  - exactly 10 `r_clk` rising edges;
  - `r_dout` sampled at those edges = 1,0,1,0,0,1,0,1,0,0;
  - `r_le`=1 only at edge 9;
  - `r_rt`=0 and `r_cd`=1 throughout;
  - `rsp_valid` 41 cycles after accept, `rsp_data`=0xA5, `rsp_parity_err`=0.
- Write RC 0x01 with the model returning parity 0. Required: `rsp_parity_err`=1, `rsp_data`=0x01.
- Read TD at CLK_DIV=4, with the model loading 0x3C on `r_le` and shifting it out MSB first. Required:
  - 9 rising edges, the first with `r_le`=1;
  - `r_rt`=`r_cd`=1 throughout;
  - `rsp_data`=0x3C, `rsp_parity_err`=0, `rsp_valid` 73 cycles after accept.
- Hold `req_valid` continuously with a TC read followed by an RC write. Required:
  - the second request is accepted in the cycle after `rsp_valid`;
  - no extra `r_clk` edges between transfers;
  - `req_ready`=0 for the whole of each transfer.
- Assert `rst_n` low during WR_SHIFT period 4 while `r_clk`=1. Required:
  - `r_clk` is 0 immediately and no `rsp_valid` is produced;
  - after release, a fresh TC read completes normally with correct data.
